// File: rtl/mem_access_unit_if.sv
// Pipeline-side and memory-bus signals of the EX_MEM load/store unit.
// The master modport is the unit's view; the slave modport is the pipeline/memory side.
interface mem_access_unit_if;
    // Pipeline (EX_MEM) side
    logic        IValid;
    logic        IMemRead;
    logic        IMemWrite;
    logic [15:0] IAddr;
    logic [15:0] IWData;
    logic        OStall;
    logic        ODone;
    logic [15:0] OReadData;
    logic        OErr;
    logic [1:0]  OErrCode;

    // Memory bus side
    logic        MemReq;
    logic        MemWe;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        MemAck;

    modport master (
        input  IValid, IMemRead, IMemWrite, IAddr, IWData, MemRData, MemAck,
        output OStall, ODone, OReadData, OErr, OErrCode,
               MemReq, MemWe, MemAddr, MemWData
    );

    modport slave (
        output IValid, IMemRead, IMemWrite, IAddr, IWData, MemRData, MemAck,
        input  OStall, ODone, OReadData, OErr, OErrCode,
               MemReq, MemWe, MemAddr, MemWData
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: stalls the pipeline while a 16-bit load/store runs on a
// request/ack memory bus, with alignment, conflict and ack-timeout error reporting.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               Reset,
    mem_access_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_READWRITE = 2'b11;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic op;
    logic rw_both;
    logic illegal;

    assign op      = bus.IValid & (bus.IMemRead | bus.IMemWrite);
    assign rw_both = bus.IMemRead & bus.IMemWrite;
    assign illegal = op & (bus.IAddr[0] | rw_both);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rdata_q     <= 16'h0000;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        err_code_d  = ERR_NONE;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                // A read+write conflict outranks misalignment in the reported code.
                if (illegal) begin
                    state_d    = DONE;
                    err_d      = 1'b1;
                    err_code_d = rw_both ? ERR_READWRITE : ERR_MISALIGN;
                end else if (op) begin
                    state_d     = ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.IMemWrite;
                    mem_addr_d  = bus.IAddr;
                    mem_wdata_d = bus.IWData;
                    wait_cnt_d  = 8'd0;
                end
            end

            ACCESS: begin
                // Ack is tested first so an ack on the final wait cycle still succeeds.
                if (bus.MemAck) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = bus.MemRData;
                    end
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    rdata_d    = 16'h0000;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Stall is combinational so the requesting instruction is frozen in its first cycle.
    assign bus.OStall    = ~Reset & (((state_q == IDLE) & op) | (state_q == ACCESS));
    assign bus.ODone     = (state_q == DONE);
    assign bus.OErr      = (state_q == DONE) & err_q;
    assign bus.OErrCode  = (state_q == DONE) ? err_code_q : ERR_NONE;
    assign bus.OReadData = rdata_q;

    assign bus.MemReq    = mem_req_q;
    assign bus.MemWe     = mem_we_q;
    assign bus.MemAddr   = mem_addr_q;
    assign bus.MemWData  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: completion results are queued at issue and
// compared on every ODone pulse; bus timing and stall lengths are checked per operation.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_count = 0;
    int          done_cyc_last = -1;
    int          done_cyc_prev = -1;
    logic [15:0] last_rd = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc_count <= cyc_count + 1;

    // Scoreboard consumer and out-of-DONE error-flag check
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ODone) begin
                done_cyc_prev = done_cyc_last;
                done_cyc_last = cyc_count;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.ODone), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_rdata", 32'(bus.OReadData), 32'(mon_e.rdata));
                    chk("done_err",   32'(bus.OErr),      32'(mon_e.err));
                    chk("done_code",  32'(bus.OErrCode),  32'(mon_e.code));
                end
            end else begin
                chk("err_outside_done", {29'd0, bus.OErr, bus.OErrCode}, 32'd0);
            end
        end
    end

    // Issues one instruction and returns at posedge+1 of the cycle after ODone.
    task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int ack_at, input logic [15:0] rdata);
        exp_t e;
        logic legal;
        int   exp_req, exp_stall, exp_done;
        int   cyc, req_n, stall_n, done_at;
        cyc = 0; req_n = 0; stall_n = 0; done_at = -1;
        legal = !(addr[0] || (rd && wr));
        if (!legal) begin
            e.rdata = last_rd; e.err = 1'b1; e.code = (rd && wr) ? 2'b11 : 2'b01;
            exp_req = 0; exp_stall = 1; exp_done = 1;
        end else if (ack_at >= 0 && ack_at < TO) begin
            e.rdata = rd ? rdata : last_rd; e.err = 1'b0; e.code = 2'b00;
            exp_req = ack_at + 1; exp_stall = ack_at + 2; exp_done = ack_at + 2;
        end else begin
            e.rdata = 16'h0000; e.err = 1'b1; e.code = 2'b10;
            exp_req = TO; exp_stall = TO + 1; exp_done = TO + 1;
        end
        last_rd = e.rdata;
        exp_q.push_back(e);

        bus.IValid = 1'b1; bus.IMemRead = rd; bus.IMemWrite = wr;
        bus.IAddr = addr; bus.IWData = wdata;
        while (done_at < 0 && cyc < 40) begin
            bus.MemAck   = legal && ack_at >= 0 && cyc == ack_at + 1;
            bus.MemRData = bus.MemAck ? rdata : ~rdata;
            @(negedge clk);
            if (bus.OStall) stall_n++;
            if (bus.MemReq) begin
                req_n++;
                chk("mem_we",   32'(bus.MemWe),   32'(wr));
                chk("mem_addr", 32'(bus.MemAddr), 32'(addr));
                if (wr) chk("mem_wdata", 32'(bus.MemWData), 32'(wdata));
            end
            if (bus.ODone) done_at = cyc;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.IValid = 1'b0; bus.IMemRead = 1'b0; bus.IMemWrite = 1'b0; bus.MemAck = 1'b0;
        if (done_at < 0) chk("done_wait_expired", 32'd0, 32'd1);
        chk("req_cycles",   32'(req_n),   32'(exp_req));
        chk("stall_cycles", 32'(stall_n), 32'(exp_stall));
        chk("done_cycle",   32'(done_at), 32'(exp_done));
        $display("op rd=%0b wr=%0b addr=%h wdata=%h ack_at=%0d -> done@%0d req=%0d stall=%0d rdata=%h err=%0b code=%0b",
                 rd, wr, addr, wdata, ack_at, done_at, req_n, stall_n, e.rdata, e.err, e.code);
    endtask

    initial begin
        bus.IValid = 1'b0; bus.IMemRead = 1'b0; bus.IMemWrite = 1'b0;
        bus.IAddr = 16'h0000; bus.IWData = 16'h0000;
        bus.MemRData = 16'h0000; bus.MemAck = 1'b0;

        // Reset values, with a pending load on the inputs to exercise stall gating
        rst = 1'b0;
        #1 rst = 1'b1;
        bus.IValid = 1'b1; bus.IMemRead = 1'b1; bus.IAddr = 16'h0010;
        #7;
        chk("rst_memreq",   32'(bus.MemReq),    32'd0);
        chk("rst_memwe",    32'(bus.MemWe),     32'd0);
        chk("rst_memaddr",  32'(bus.MemAddr),   32'd0);
        chk("rst_memwdata", 32'(bus.MemWData),  32'd0);
        chk("rst_rdata",    32'(bus.OReadData), 32'd0);
        chk("rst_done",     32'(bus.ODone),     32'd0);
        chk("rst_err",      32'(bus.OErr),      32'd0);
        chk("rst_code",     32'(bus.OErrCode),  32'd0);
        chk("rst_stall",    32'(bus.OStall),    32'd0);
        bus.IValid = 1'b0; bus.IMemRead = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Minimum-latency load, then a store with three wait cycles
        do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF);
        do_op(1'b0, 1'b1, 16'h0020, 16'h1234, 3, 16'h0000);

        // Illegal operations
        do_op(1'b1, 1'b0, 16'h0021, 16'h0000, 0, 16'h5555);
        do_op(1'b1, 1'b1, 16'h0022, 16'h0000, 0, 16'h5555);
        do_op(1'b1, 1'b1, 16'h0023, 16'h0000, 0, 16'h5555);

        // Timeout, ack on the final wait cycle, and ack arriving only in DONE
        do_op(1'b1, 1'b0, 16'h0030, 16'h0000, -1, 16'h7777);
        do_op(1'b1, 1'b0, 16'h0032, 16'h0000, TO - 1, 16'h5A5A);
        do_op(1'b1, 1'b0, 16'h0034, 16'h0000, TO, 16'h6B6B);

        // Back-to-back loads
        do_op(1'b1, 1'b0, 16'h0002, 16'h0000, 0, 16'h1111);
        do_op(1'b1, 1'b0, 16'h0004, 16'h0000, 0, 16'h2222);
        chk("b2b_done_gap", 32'(done_cyc_last - done_cyc_prev), 32'd3);

        // Ack while idle is ignored
        bus.MemAck = 1'b1; bus.MemRData = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_ack_done",  32'(bus.ODone),     32'd0);
            chk("idle_ack_req",   32'(bus.MemReq),    32'd0);
            chk("idle_ack_rdata", 32'(bus.OReadData), 32'(last_rd));
            @(posedge clk);
            #1;
        end
        bus.MemAck = 1'b0;

        // Randomised legal loads/stores with assorted ack delays
        for (int i = 0; i < 8; i++) begin
            logic        r;
            logic [15:0] a;
            int          d;
            r = 1'($urandom_range(0, 1));
            a = 16'($urandom) & 16'hFFFE;
            d = int'($urandom_range(0, 5));
            if (d == 5) d = -1;
            do_op(r, !r, a, 16'($urandom), d, 16'($urandom));
        end

        // Reset between clock edges during ACCESS
        bus.IValid = 1'b1; bus.IMemRead = 1'b1; bus.IAddr = 16'h0040;
        bus.MemRData = 16'hCAFE;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_memreq", 32'(bus.MemReq), 32'd0);
        chk("midrst_stall",  32'(bus.OStall), 32'd0);
        chk("midrst_done",   32'(bus.ODone),  32'd0);
        chk("midrst_rdata",  32'(bus.OReadData), 32'd0);
        last_rd = 16'h0000;
        bus.IValid = 1'b0; bus.IMemRead = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        bus.MemAck = 1'b1;
        @(posedge clk); #1;
        bus.MemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done",  32'(bus.ODone),     32'd0);
            chk("post_rst_rdata", 32'(bus.OReadData), 32'd0);
        end
        @(posedge clk); #1;

        // Unit still operational after the aborted access
        do_op(1'b1, 1'b0, 16'h0050, 16'h0000, 1, 16'hA5A5);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
